// File: rtl/synth_pkg.sv
// Shared types and default sizing for the synth frame scheduler: note event record,
// slot-count constants and the frame FSM state encoding.
package synth_pkg;

    localparam int DEF_VOICES   = 8;
    localparam int DEF_V_OSC    = 4;
    localparam int DEF_O_ENVS   = 2;
    localparam int DEF_V_WIDTH  = 3;
    localparam int DEF_E_WIDTH  = 3;
    localparam int DEF_EV_DEPTH = 4;

    localparam int V_ENVS     = DEF_V_OSC * DEF_O_ENVS;
    localparam int SLOT_COUNT = DEF_VOICES * V_ENVS;

    typedef struct packed {
        logic [DEF_V_WIDTH-1:0] key_adr;
        logic [7:0]             key_val;
        logic [7:0]             vel_on;
    } note_ev_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/synth_frame_scheduler_if.sv
// Signal bundle between the voice engine control side (master) and the frame scheduler (slave).
interface synth_frame_scheduler_if
    import synth_pkg::*;
#(
    parameter int VOICES  = DEF_VOICES,
    parameter int V_WIDTH = DEF_V_WIDTH,
    parameter int E_WIDTH = DEF_E_WIDTH
);
    logic                       trig;
    logic                       note_on;
    logic [V_WIDTH-1:0]         cur_key_adr;
    logic [7:0]                 cur_key_val;
    logic [7:0]                 cur_vel_on;
    logic [VOICES-1:0]          keys_on;

    logic [V_WIDTH+E_WIDTH-1:0] xxxx;
    logic                       xxxx_zero;
    logic                       frame_busy;
    logic                       reg_note_on;
    logic [V_WIDTH-1:0]         reg_cur_key_adr;
    logic [7:0]                 reg_cur_key_val;
    logic [7:0]                 reg_cur_vel_on;
    logic [VOICES-1:0]          reg_keys_on;
    logic                       ev_overflow;
    logic                       frame_overrun;

    modport master (
        output trig, note_on, cur_key_adr, cur_key_val, cur_vel_on, keys_on,
        input  xxxx, xxxx_zero, frame_busy, reg_note_on, reg_cur_key_adr,
               reg_cur_key_val, reg_cur_vel_on, reg_keys_on, ev_overflow, frame_overrun
    );

    modport slave (
        input  trig, note_on, cur_key_adr, cur_key_val, cur_vel_on, keys_on,
        output xxxx, xxxx_zero, frame_busy, reg_note_on, reg_cur_key_adr,
               reg_cur_key_val, reg_cur_vel_on, reg_keys_on, ev_overflow, frame_overrun
    );

endinterface

// File: rtl/note_event_fifo.sv
// Note-event FIFO with wrap-bit pointers; optional coalescing of a push into the newest
// un-popped entry when the voice matches (enabled through the coalesce port).
module note_event_fifo
    import synth_pkg::*;
#(
    parameter int EV_DEPTH = DEF_EV_DEPTH
) (
    input  logic     clk,
    input  logic     srst,
    input  logic     coalesce,
    input  logic     push,
    input  note_ev_t push_data,
    input  logic     pop,
    output note_ev_t head,
    output logic     full,
    output logic     empty,
    output logic     merged
);
    localparam int EV_AW = $clog2(EV_DEPTH);
    localparam logic [EV_AW:0] PTR_ONE = 1;

    note_ev_t         mem [EV_DEPTH];
    logic [EV_AW:0]   wr_ptr_reg;
    logic [EV_AW:0]   rd_ptr_reg;
    logic [EV_AW:0]   newest_ptr;
    logic [EV_AW:0]   count;
    logic [EV_AW-1:0] wr_idx;
    logic             do_pop;
    logic             do_push;

    assign empty      = (wr_ptr_reg == rd_ptr_reg);
    assign full       = (wr_ptr_reg[EV_AW] != rd_ptr_reg[EV_AW]) &&
                        (wr_ptr_reg[EV_AW-1:0] == rd_ptr_reg[EV_AW-1:0]);
    assign head       = mem[rd_ptr_reg[EV_AW-1:0]];
    assign newest_ptr = wr_ptr_reg - PTR_ONE;
    assign count      = wr_ptr_reg - rd_ptr_reg;
    assign do_pop     = pop && !empty;

    // A merge is only safe if the newest entry survives this cycle's pop.
    assign merged  = coalesce && push && !empty &&
                     (mem[newest_ptr[EV_AW-1:0]].key_adr == push_data.key_adr) &&
                     !(do_pop && (count == PTR_ONE));
    assign do_push = push && !merged && (!full || do_pop);
    assign wr_idx  = merged ? newest_ptr[EV_AW-1:0] : wr_ptr_reg[EV_AW-1:0];

    always_ff @(posedge clk) begin
        if (!srst && (merged || do_push)) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/synth_frame_scheduler.sv
// Frame slot sequencer with queued note-event application at frame start.
// Optional build macro EV_COALESCE_EN: same-voice pushes overwrite the newest queued event.
module synth_frame_scheduler
    import synth_pkg::*;
#(
    parameter int VOICES   = DEF_VOICES,
    parameter int V_OSC    = DEF_V_OSC,
    parameter int O_ENVS   = DEF_O_ENVS,
    parameter int V_WIDTH  = DEF_V_WIDTH,
    parameter int E_WIDTH  = DEF_E_WIDTH,
    parameter int EV_DEPTH = DEF_EV_DEPTH
) (
    input logic                    OSC_CLK,
    input logic                    reset_reg,
    synth_frame_scheduler_if.slave bus
);
    localparam int SW    = V_WIDTH + E_WIDTH;
    localparam int SLOTS = VOICES * V_OSC * O_ENVS;
    localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);
    localparam logic [SW-1:0] SLOT_ONE  = 1;

`ifdef EV_COALESCE_EN
    localparam logic COALESCE = 1'b1;
`else
    localparam logic COALESCE = 1'b0;
`endif

    state_t            state_reg;
    state_t            state_next;
    logic [SW-1:0]     slot_reg;
    logic              last_slot;
    logic              accept;
    logic              overrun_hit;

    note_ev_t          push_ev;
    note_ev_t          head_ev;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_merged;
    logic              drop;

    logic              note_reg;
    note_ev_t          cur_reg;
    logic [VOICES-1:0] keys_reg;
    logic              ev_overflow_reg;
    logic              frame_overrun_reg;

    assign last_slot   = (slot_reg == LAST_SLOT);
    assign accept      = (state_reg == ST_IDLE) && bus.trig;
    assign overrun_hit = (state_reg == ST_RUN) && bus.trig;

    assign push_ev.key_adr = bus.cur_key_adr;
    assign push_ev.key_val = bus.cur_key_val;
    assign push_ev.vel_on  = bus.cur_vel_on;

    note_event_fifo #(
        .EV_DEPTH (EV_DEPTH)
    ) u_fifo (
        .clk       (OSC_CLK),
        .srst      (reset_reg),
        .coalesce  (COALESCE),
        .push      (bus.note_on),
        .push_data (push_ev),
        .pop       (accept),
        .head      (head_ev),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .merged    (fifo_merged)
    );

    // A push into a full FIFO survives only if the frame start frees a slot in the same cycle.
    assign drop = bus.note_on && !fifo_merged && fifo_full && !(accept && !fifo_empty);

    always_ff @(posedge OSC_CLK) begin
        if (reset_reg) begin
            state_reg <= ST_IDLE;
            slot_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_RUN) && !last_slot) begin
                slot_reg <= slot_reg + SLOT_ONE;
            end else begin
                slot_reg <= '0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.trig) state_next = ST_RUN;
            ST_RUN:  if (last_slot) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.xxxx       = slot_reg;
        bus.frame_busy = (state_reg == ST_RUN);
        bus.xxxx_zero  = (state_reg == ST_RUN) && (slot_reg == '0);
    end

    always_ff @(posedge OSC_CLK) begin
        if (reset_reg) begin
            note_reg          <= 1'b0;
            cur_reg           <= '0;
            keys_reg          <= '0;
            ev_overflow_reg   <= 1'b0;
            frame_overrun_reg <= 1'b0;
        end else begin
            if (accept) begin
                keys_reg <= bus.keys_on;
                note_reg <= !fifo_empty;
                if (!fifo_empty) begin
                    cur_reg <= head_ev;
                end
            end else if ((state_reg == ST_RUN) && last_slot) begin
                note_reg <= 1'b0;
            end
            if (drop) begin
                ev_overflow_reg <= 1'b1;
            end
            if (overrun_hit) begin
                frame_overrun_reg <= 1'b1;
            end
        end
    end

    assign bus.reg_note_on     = note_reg;
    assign bus.reg_cur_key_adr = cur_reg.key_adr;
    assign bus.reg_cur_key_val = cur_reg.key_val;
    assign bus.reg_cur_vel_on  = cur_reg.vel_on;
    assign bus.reg_keys_on     = keys_reg;
    assign bus.ev_overflow     = ev_overflow_reg;
    assign bus.frame_overrun   = frame_overrun_reg;

endmodule
